// File: rtl/enemies_formation_move.sv
`default_nettype none
// ============================================================================
//  Module   : enemies_formation_move
//  Purpose  : Invaders-style row formation: per-frame slide/reverse/step-down,
//             per-enemy alive tracking and per-pixel draw request.
//  Option   : define ENEMIES_SPEEDUP_EN to speed the row up as enemies die.
//  Revision : 1.0  initial release
// ============================================================================
module enemies_formation_move #(
    parameter int NUM_ENEMIES     = 8,
    parameter int INITIAL_X       = 40,
    parameter int INITIAL_Y       = 100,
    parameter int OBJECT_WIDTH_X  = 30,
    parameter int OBJECT_HEIGHT_Y = 30,
    parameter int SPACING_X       = 64,
    parameter int X_SPEED         = 128,
    parameter int STEP_DOWN_Y     = 16,
    parameter int SCREEN_WIDTH    = 640,
    parameter int BOTTOM_LIMIT_Y  = 400,
    parameter int SPEEDUP_STEP    = 16,
    localparam int IW             = $clog2(NUM_ENEMIES)
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic [10:0]            pixelX,
    input  logic [10:0]            pixelY,
    input  logic                   hitValid,
    input  logic [IW-1:0]          hitIndex,
    output logic                   drawingRequest,
    output logic [10:0]            offsetX,
    output logic [10:0]            offsetY,
    output logic [IW-1:0]          enemyIndex,
    output logic [NUM_ENEMIES-1:0] aliveMask,
    output logic                   allDead,
    output logic                   reachedBottom
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t                   r_state, w_state_next;
    logic signed [31:0]       r_pos_x_fp;
    logic [10:0]              r_pos_y;
    logic                     r_dir_left;
    logic [NUM_ENEMIES-1:0]   r_alive;
    logic [NUM_ENEMIES-1:0]   r_snap;
    logic [IW-1:0]            r_scan_idx;
    logic [IW-1:0]            r_min_idx;
    logic [IW-1:0]            r_max_idx;
    logic [IW:0]              r_live_cnt;
    logic                     r_reached_bottom;

    logic signed [31:0]       w_pos_x;
    logic signed [31:0]       w_pix_x;
    logic signed [31:0]       w_pix_y;
    logic signed [31:0]       w_pos_y_s;
    logic                     w_in_y;
    logic signed [31:0]       w_slot_left [NUM_ENEMIES];
    logic [NUM_ENEMIES-1:0]   w_slot_hit;
    logic                     w_hit;
    logic [IW-1:0]            w_idx;
    logic [10:0]              w_off_x;
    logic [10:0]              w_off_y;
    logic                     w_hit_ok;
    logic                     w_scan_last;
    logic signed [31:0]       w_speed;
    logic signed [31:0]       w_left_edge;
    logic signed [31:0]       w_right_edge;
    logic                     w_reverse;
    logic                     w_move;
    logic [11:0]              w_pos_y_sum;
    logic [10:0]              w_pos_y_down;
    logic [10:0]              w_pos_y_after;
    logic                     w_bottom_next;

    // ------------------------------------------------------------------
    // Pixel hit test against every slot in parallel
    // ------------------------------------------------------------------
    assign w_pos_x   = r_pos_x_fp >>> 6;
    assign w_pix_x   = $signed({21'd0, pixelX});
    assign w_pix_y   = $signed({21'd0, pixelY});
    assign w_pos_y_s = $signed({21'd0, r_pos_y});
    assign w_in_y    = (w_pix_y >= w_pos_y_s) && (w_pix_y < w_pos_y_s + OBJECT_HEIGHT_Y);

    for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_slot
        assign w_slot_left[g] = w_pos_x + g * SPACING_X;
        assign w_slot_hit[g]  = r_alive[g] && w_in_y &&
                                (w_pix_x >= w_slot_left[g]) &&
                                (w_pix_x <  w_slot_left[g] + OBJECT_WIDTH_X);
    end

    // Walk downwards so the lowest matching slot is the one kept
    always_comb begin
        w_hit   = 1'b0;
        w_idx   = '0;
        w_off_x = '0;
        w_off_y = '0;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            if (w_slot_hit[i]) begin
                w_hit   = 1'b1;
                w_idx   = IW'(i);
                w_off_x = pixelX - w_slot_left[i][10:0];
                w_off_y = pixelY - r_pos_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            drawingRequest <= 1'b0;
            offsetX        <= '0;
            offsetY        <= '0;
            enemyIndex     <= '0;
        end else begin
            drawingRequest <= w_hit;
            offsetX        <= w_off_x;
            offsetY        <= w_off_y;
            enemyIndex     <= w_idx;
        end
    end

    // Index range check only matters when N is not a power of two
    if ((1 << IW) == NUM_ENEMIES) begin : g_idx_full
        assign w_hit_ok = 1'b1;
    end else begin : g_idx_partial
        assign w_hit_ok = (32'(hitIndex) < NUM_ENEMIES);
    end

    // ------------------------------------------------------------------
    // Frame update arithmetic (fixed point, 6 fractional bits)
    // ------------------------------------------------------------------
`ifdef ENEMIES_SPEEDUP_EN
    assign w_speed = X_SPEED + (NUM_ENEMIES - $signed({{(31-IW){1'b0}}, r_live_cnt})) * SPEEDUP_STEP;
`else
    assign w_speed = X_SPEED;
`endif

    assign w_left_edge  = r_pos_x_fp + $signed({{(32-IW){1'b0}}, r_min_idx}) * (SPACING_X * 64);
    assign w_right_edge = r_pos_x_fp +
                          ($signed({{(32-IW){1'b0}}, r_max_idx}) * SPACING_X + OBJECT_WIDTH_X) * 64;
    assign w_reverse    = r_dir_left ? (w_left_edge - w_speed < 0)
                                     : (w_right_edge + w_speed > SCREEN_WIDTH * 64);
    assign w_move       = (r_live_cnt != '0) && !r_reached_bottom;

    assign w_pos_y_sum   = {1'b0, r_pos_y} + 12'(STEP_DOWN_Y);
    assign w_pos_y_down  = w_pos_y_sum[11] ? 11'h7FF : w_pos_y_sum[10:0];
    assign w_pos_y_after = (w_move && w_reverse) ? w_pos_y_down : r_pos_y;
    assign w_bottom_next = ({21'd0, w_pos_y_after} + 32'(OBJECT_HEIGHT_Y)) >= 32'(BOTTOM_LIMIT_Y);
    assign w_scan_last   = (r_scan_idx == IW'(NUM_ENEMIES - 1));

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (startOfFrame) w_state_next = S_SCAN;
            S_SCAN:   if (w_scan_last)  w_state_next = S_UPDATE;
            S_UPDATE: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_pos_x_fp       <= INITIAL_X * 64;
            r_pos_y          <= 11'(INITIAL_Y);
            r_dir_left       <= 1'b0;
            r_alive          <= '1;
            r_snap           <= '0;
            r_scan_idx       <= '0;
            r_min_idx        <= '0;
            r_max_idx        <= '0;
            r_live_cnt       <= '0;
            r_reached_bottom <= 1'b0;
        end else begin
            if (hitValid && w_hit_ok) r_alive[hitIndex] <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (startOfFrame) begin
                        r_snap     <= r_alive;
                        r_scan_idx <= '0;
                        r_min_idx  <= '0;
                        r_max_idx  <= '0;
                        r_live_cnt <= '0;
                    end
                end
                S_SCAN: begin
                    r_scan_idx <= r_scan_idx + 1'b1;
                    if (r_snap[r_scan_idx]) begin
                        if (r_live_cnt == '0) r_min_idx <= r_scan_idx;
                        r_max_idx  <= r_scan_idx;
                        r_live_cnt <= r_live_cnt + 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (w_move) begin
                        if (w_reverse) begin
                            r_dir_left <= ~r_dir_left;
                            r_pos_y    <= w_pos_y_down;
                        end else if (r_dir_left) begin
                            r_pos_x_fp <= r_pos_x_fp - w_speed;
                        end else begin
                            r_pos_x_fp <= r_pos_x_fp + w_speed;
                        end
                    end
                    if (w_bottom_next) r_reached_bottom <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign aliveMask     = r_alive;
    assign allDead       = (r_alive == '0);
    assign reachedBottom = r_reached_bottom;

endmodule
`default_nettype wire
